// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - two-requester arbiter/sequencer for a single-port 128x32 memory
// Define ARB_ROUND_ROBIN_EN for round-robin tie-breaking; otherwise requester 0 wins ties.
module mem_arbiter #(
    parameter int ADDR_W = 7,
    parameter int DATA_W = 32
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              req0,
    input  logic              req1,
    input  logic              we0,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    output logic              ack0,
    output logic              ack1,
    output logic [DATA_W-1:0] rdata0,
    output logic [DATA_W-1:0] rdata1,
    output logic              CS,
    output logic              WE,
    output logic [ADDR_W-1:0] ADDR,
    inout  wire  [DATA_W-1:0] Mem_Bus
);

`ifdef ARB_ROUND_ROBIN_EN
    localparam bit RR_EN = 1'b1;
`else
    localparam bit RR_EN = 1'b0;
`endif

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_ACK    = 2'd2
    } state_t;

    state_t              r_state;
    logic                r_cs;
    logic                r_we;
    logic [ADDR_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_wdata;
    logic                r_ack0;
    logic                r_ack1;
    logic [DATA_W-1:0]   r_rdata0;
    logic [DATA_W-1:0]   r_rdata1;
    logic                r_grant_id;
    logic                r_last_grant;

    logic                w_any_req;
    logic                w_winner;
    logic                w_win_we;
    logic [ADDR_W-1:0]   w_win_addr;
    logic [DATA_W-1:0]   w_win_wdata;
    logic                w_bus_oe;

    assign w_any_req = req0 | req1;

    // On a tie the fixed-priority build always picks requester 0.
    always_comb begin
        w_winner = req1 & ~req0;
        if (req0 && req1) begin
            w_winner = RR_EN & ~r_last_grant;
        end
    end

    assign w_win_we    = w_winner ? we1    : we0;
    assign w_win_addr  = w_winner ? addr1  : addr0;
    assign w_win_wdata = w_winner ? wdata1 : wdata0;

    // Memory only drives when CS=1 and WE=0, so this never contends with it.
    assign w_bus_oe = (r_state == S_ACCESS) && r_we;
    assign Mem_Bus  = w_bus_oe ? r_wdata : {DATA_W{1'bz}};

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state      <= S_IDLE;
            r_cs         <= 1'b0;
            r_we         <= 1'b0;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_ack0       <= 1'b0;
            r_ack1       <= 1'b0;
            r_rdata0     <= '0;
            r_rdata1     <= '0;
            r_grant_id   <= 1'b0;
            r_last_grant <= 1'b1;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_any_req) begin
                        r_cs         <= 1'b1;
                        r_we         <= w_win_we;
                        r_addr       <= w_win_addr;
                        r_wdata      <= w_win_wdata;
                        r_grant_id   <= w_winner;
                        r_last_grant <= w_winner;
                        r_state      <= S_ACCESS;
                    end
                end
                S_ACCESS: begin
                    // Memory loaded its output register on the preceding negedge.
                    if (!r_we) begin
                        if (r_grant_id) begin
                            r_rdata1 <= Mem_Bus;
                        end else begin
                            r_rdata0 <= Mem_Bus;
                        end
                    end
                    r_cs    <= 1'b0;
                    r_we    <= 1'b0;
                    r_ack0  <= ~r_grant_id;
                    r_ack1  <= r_grant_id;
                    r_state <= S_ACK;
                end
                S_ACK: begin
                    r_ack0  <= 1'b0;
                    r_ack1  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign CS     = r_cs;
    assign WE     = r_we;
    assign ADDR   = r_addr;
    assign ack0   = r_ack0;
    assign ack1   = r_ack1;
    assign rdata0 = r_rdata0;
    assign rdata1 = r_rdata1;

endmodule
